// File: rtl/pe_result_accum_if.sv
// Tile bus shared by the PE result input and the writeback output of pe_result_accum.
// Master drives tile/tag/valid; slave returns ready.
interface pe_result_accum_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 9,
  parameter int OD_W   = 8
);
  logic [5:0][5:0][DATA_W-1:0] tile;
  logic [OD_W-1:0]             od;
  logic [IDX_W-1:0]            x_index;
  logic [IDX_W-1:0]            y_index;
  logic                        valid;
  logic                        ready;

  modport master (output tile, od, x_index, y_index, valid, input ready);
  modport slave  (input tile, od, x_index, y_index, valid, output ready);
endinterface

// File: rtl/pe_result_accum.sv
// Multi-slot accumulator summing num_ic_i partial 6x6 tiles per {od,x,y} tag, then
// draining saturated tiles over valid/ready. Optional ReLU: PE_RESULT_ACCUM_RELU_EN.
module pe_result_accum #(
  parameter int SLOTS  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int IDX_W  = 9,
  parameter int OD_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  pe_result_accum_if.slave         result_if,
  input  logic [7:0]               num_ic_i,
  output logic                     stall_o,
  output logic                     drop_err_o,
  pe_result_accum_if.master        out_if
);
  localparam int TAG_W  = OD_W + 2 * IDX_W;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {SLOT_FREE, SLOT_ACCUM, SLOT_DONE} slot_e;
  typedef enum logic {DR_IDLE, DR_PRESENT} drain_e;
  typedef logic [5:0][5:0][ACC_W-1:0]  acc_tile_t;
  typedef logic [5:0][5:0][DATA_W-1:0] out_tile_t;

  slot_e             slot_q [SLOTS];
  slot_e             slot_d [SLOTS];
  logic [TAG_W-1:0]  tag_q  [SLOTS];
  logic [TAG_W-1:0]  tag_d  [SLOTS];
  acc_tile_t         acc_q  [SLOTS];
  acc_tile_t         acc_d  [SLOTS];
  logic [7:0]        cnt_q  [SLOTS];
  logic [7:0]        cnt_d  [SLOTS];

  drain_e            drain_q, drain_d;
  logic [SLOT_W-1:0] sel_q, sel_d;
  out_tile_t         out_tile_q, out_tile_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              out_valid_q, out_valid_d;
  logic              stall_q, stall_d;
  logic              drop_err_q, drop_err_d;

  logic [TAG_W-1:0]  in_tag;
  logic [7:0]        target;
  logic              accept;
  logic              hit, free_found, done_found, wr_en;
  logic [SLOT_W-1:0] hit_idx, free_idx, done_idx, wr_idx;
  logic [7:0]        cnt_new;

  function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sat_elem(input logic [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    logic [DATA_W-1:0]       r;
    v  = $signed(a);
    hi = $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    lo = $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});
    if (v > hi)      r = {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < lo) r = {1'b1, {(DATA_W-1){1'b0}}};
    else             r = a[DATA_W-1:0];
`ifdef PE_RESULT_ACCUM_RELU_EN
    if (r[DATA_W-1]) r = '0;
`endif
    return r;
  endfunction

  function automatic out_tile_t sat_tile(input acc_tile_t a);
    out_tile_t t;
    for (int unsigned r = 0; r < 6; r++) begin
      for (int unsigned c = 0; c < 6; c++) begin
        t[r][c] = sat_elem(a[r][c]);
      end
    end
    return t;
  endfunction

  // Slot search: tag hit among ACCUM slots, lowest FREE, lowest DONE.
  always_comb begin
    in_tag     = {result_if.od, result_if.x_index, result_if.y_index};
    target     = (num_ic_i == 8'd0) ? 8'd1 : num_ic_i;
    accept     = result_if.valid && !stall_q;
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    done_found = 1'b0;
    done_idx   = '0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (!hit && slot_q[s] == SLOT_ACCUM && tag_q[s] == in_tag) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(s);
      end
      if (!free_found && slot_q[s] == SLOT_FREE) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(s);
      end
      if (!done_found && slot_q[s] == SLOT_DONE) begin
        done_found = 1'b1;
        done_idx   = SLOT_W'(s);
      end
    end
    wr_en  = accept && (hit || free_found);
    wr_idx = hit ? hit_idx : free_idx;
  end

  always_comb begin
    slot_d      = slot_q;
    tag_d       = tag_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    sel_d       = sel_q;
    out_tile_d  = out_tile_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    cnt_new     = 8'd0;
    drop_err_d  = drop_err_q | (result_if.valid && stall_q);

    if (wr_en) begin
      for (int unsigned r = 0; r < 6; r++) begin
        for (int unsigned c = 0; c < 6; c++) begin
          acc_d[wr_idx][r][c] = hit ? acc_q[wr_idx][r][c] + sext(result_if.tile[r][c])
                                    : sext(result_if.tile[r][c]);
        end
      end
      cnt_new        = hit ? cnt_q[wr_idx] + 8'd1 : 8'd1;
      cnt_d[wr_idx]  = cnt_new;
      tag_d[wr_idx]  = in_tag;
      slot_d[wr_idx] = (cnt_new == target) ? SLOT_DONE : SLOT_ACCUM;
    end

    // Selection looks at slot_q, so a slot completing this edge waits one cycle.
    case (drain_q)
      DR_IDLE: begin
        if (done_found) begin
          sel_d       = done_idx;
          out_tile_d  = sat_tile(acc_q[done_idx]);
          out_tag_d   = tag_q[done_idx];
          out_valid_d = 1'b1;
          drain_d     = DR_PRESENT;
        end
      end
      DR_PRESENT: begin
        if (out_valid_q && out_if.ready) begin
          slot_d[sel_q] = SLOT_FREE;
          out_valid_d   = 1'b0;
          drain_d       = DR_IDLE;
        end
      end
      default: drain_d = DR_IDLE;
    endcase

    stall_d = 1'b1;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (slot_d[s] == SLOT_FREE) stall_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        slot_q[s] <= SLOT_FREE;
        tag_q[s]  <= '0;
        acc_q[s]  <= '0;
        cnt_q[s]  <= '0;
      end
      drain_q     <= DR_IDLE;
      sel_q       <= '0;
      out_tile_q  <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        slot_q[s] <= slot_d[s];
        tag_q[s]  <= tag_d[s];
        acc_q[s]  <= acc_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      drain_q     <= drain_d;
      sel_q       <= sel_d;
      out_tile_q  <= out_tile_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign result_if.ready = !stall_q;
  assign stall_o         = stall_q;
  assign drop_err_o      = drop_err_q;
  assign out_if.tile     = out_tile_q;
  assign out_if.valid    = out_valid_q;
  assign {out_if.od, out_if.x_index, out_if.y_index} = out_tag_q;
endmodule
